hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised, clocked successor to the pipeline's combinational hazard detector. It keeps a per-register countdown scoreboard of in-flight writes and stalls the ID stage on the following hazards:
- load-use,
- branch-in-ID RAW,
- WAW between producers of different latency.

Producer latency is configurable, so the same block serves single-cycle and multi-cycle memory. It also counts stall cycles for performance analysis.

## Interface
Parameters:
- REG_AW, 5, register index width; 2**REG_AW scoreboard entries, register 0 never tracked
- NUM_SRC, 2, source operands per instruction (1..4)
- ALU_LAT, 1, cycles after issue until an ALU result is forwardable to ID (>=1)
- LOAD_LAT, 2, cycles after issue until load data is forwardable to ID (>=ALU_LAT)
- CW, derived, clog2(LOAD_LAT+1), counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_src  in  NUM_SRC*REG_AW  source register indices; source i occupies bits [i*REG_AW +: REG_AW]
- id_src_used  in  NUM_SRC  source i is actually read
- id_branch  in  1  instruction consumes operands in ID (branch compare)
- id_regwrite  in  1  instruction writes id_dst
- id_memread  in  1  instruction is a load
- id_dst  in  REG_AW  destination register
- flush  in  1  ID instruction is squashed this cycle
- perf_clr  in  1  synchronous clear of stall_count
- pc_write  out  1  PC may advance
- ifid_write  out  1  IF/ID may load
- bubble  out  1  insert NOP into ID/EX
- stall_cause  out  2  0 none, 1 RAW non-branch, 2 RAW branch, 3 WAW
- stall_count  out  32  saturating count of stalled cycles

## Operation
- State: one CW-bit counter cnt[r] per register r. cnt[r] is the number of cycles until the pending write to r becomes forwardable. cnt[0] reads as 0 at all times.
- Required readiness for a source:
  - 0 if id_branch,
  - 1 otherwise (the operand is consumed in EX one cycle later).
- raw_i: id_src_used[i] && src_i!=0 && cnt[src_i] > readiness.
- waw: id_regwrite && id_dst!=0 && cnt[id_dst] > new_lat, where new_lat = id_memread ? LOAD_LAT : ALU_LAT.
- stall = id_valid && !flush && (any raw_i || waw). This is combinational from registered counters.
- pc_write = ifid_write = !stall; bubble = stall.
- stall_cause priority when stall is asserted:
  - 2 if any raw_i and id_branch,
  - else 1 if any raw_i,
  - else 3.
  - stall_cause is 0 when stall is deasserted.
- issue = id_valid && !flush && !stall.
- Counter update at each edge:
  - If issue && id_regwrite && id_dst!=0, cnt[id_dst] <= new_lat. The set overrides the decrement for that entry.
  - Every other nonzero counter decrements by 1; zero counters hold.
- flush takes priority over all hazards: no stall, no issue, no counter set. In-flight counters keep decrementing.
- stall_count:
  - perf_clr wins and sets it to 0;
  - else it increments on stall cycles;
  - it saturates at 32'hFFFF_FFFF.

## Timing
- Reset (asynchronous, active-low): all cnt cleared, stall_count=0. Outputs are then pc_write=1, ifid_write=1, bubble=0, stall_cause=0.
- Reset asserted mid-stall releases the stall immediately, without waiting for the clock.
- A producer issued at edge t is visible to the ID instruction in cycle t+1, with cnt equal to its latency.
- Stall length, with the default parameters:
  - Non-branch consumer directly behind a producer: stalls LAT-1 cycles (load 1, ALU 0).
  - Branch consumer directly behind a producer: stalls LAT cycles (load 2, ALU 1).
- Back-to-back issues to the same dst: the latest issue overwrites the counter. The WAW check guarantees the new value is never smaller than the remaining count.
- Outputs settle combinationally within the same cycle as the ID inputs. There is no extra pipeline latency.

## Test plan
- Reset: run lw $8 then add $9,$8 and assert rst_n low while stall=1. Required response:
  - bubble=0 and pc_write=1 asynchronously;
  - after release, add $9,$8 issues with no stall;
  - stall_count=0.
- Load-use: lw $8 then add $10,$8,$9. Required response: exactly 1 stall cycle, stall_cause=1, stall_count=1, then issue.
- Branch RAW:
  - add $8 followed by beq $8,$9: 1 stall, cause=2.
  - lw $8 followed by beq $8,$0: 2 stalls, cause=2.
- Register zero: lw $0 then add $1,$0,$0. Required response: no stall, cnt never set.
- WAW with LOAD_LAT=4: lw $5 then addi $5,$6,1. Required response: 3 stall cycles with cause=3, then issue; cnt[5] is reloaded to 1.
- Flush and counter: flush=1 while a load-use hazard is present. Required response:
  - stall=0 and no counter set; the pending load counter still decrements;
  - perf_clr during a stall gives stall_count=0 on the next cycle.
  - Saturation: preload near the maximum, then stall. Required response: stall_count holds at FFFF_FFFF.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - countdown scoreboard that stalls ID on RAW/WAW hazards
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2,
  parameter int CW       = $clog2(LOAD_LAT + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      id_branch,
  input  logic                      id_regwrite,
  input  logic                      id_memread,
  input  logic [REG_AW-1:0]         id_dst,
  input  logic                      flush,
  input  logic                      perf_clr,
  output logic                      pc_write,
  output logic                      ifid_write,
  output logic                      bubble,
  output logic [1:0]                stall_cause,
  output logic [31:0]               stall_count
);

  localparam int NREG = 1 << REG_AW;

  logic [CW-1:0]     r_cnt [NREG];
  logic [31:0]       r_stall_count;
  logic [REG_AW-1:0] w_src [NUM_SRC];
  logic [CW-1:0]     w_need;
  logic [CW-1:0]     w_new_lat;
  logic              w_raw;
  logic              w_waw;
  logic              w_stall;
  logic              w_issue;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign w_src[g] = id_src[g*REG_AW +: REG_AW];
  end

  // A branch compares in ID and needs the value now; others read it one cycle later in EX.
  assign w_need    = id_branch ? '0 : CW'(1);
  assign w_new_lat = id_memread ? CW'(LOAD_LAT) : CW'(ALU_LAT);

  always_comb begin
    w_raw = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i] && (w_src[i] != '0) && (r_cnt[w_src[i]] > w_need)) begin
        w_raw = 1'b1;
      end
    end
  end

  assign w_waw   = id_regwrite && (id_dst != '0) && (r_cnt[id_dst] > w_new_lat);
  assign w_stall = id_valid && !flush && (w_raw || w_waw);
  assign w_issue = id_valid && !flush && !w_stall;

  assign pc_write    = !w_stall;
  assign ifid_write  = !w_stall;
  assign bubble      = w_stall;
  assign stall_count = r_stall_count;

  always_comb begin
    stall_cause = 2'd0;
    if (w_stall) begin
      if (w_raw && id_branch) stall_cause = 2'd2;
      else if (w_raw)         stall_cause = 2'd1;
      else                    stall_cause = 2'd3;
    end
  end

  // Entry 0 is cleared by reset and never written afterwards, so it always reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (w_issue && id_regwrite && (id_dst == REG_AW'(r))) r_cnt[r] <= w_new_lat;
        else if (r_cnt[r] != '0)                              r_cnt[r] <= r_cnt[r] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        r_stall_count <= '0;
    else if (perf_clr)                                 r_stall_count <= '0;
    else if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) r_stall_count <= r_stall_count + 32'd1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed and random checks of two scoreboard configurations
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic        id_branch;
  logic        id_regwrite;
  logic        id_memread;
  logic [4:0]  id_dst;
  logic        flush;
  logic        perf_clr;
  logic        a_pc_write, a_ifid_write, a_bubble;
  logic        b_pc_write, b_ifid_write, b_bubble;
  logic [1:0]  a_cause, b_cause;
  logic [31:0] a_sc, b_sc;

  int total = 0;
  int bad   = 0;

  // Model: absolute cycle at which each register's pending write becomes forwardable.
  int          ready_at [2][32];
  int          lload [2] = '{2, 4};
  logic [31:0] sc_m [2];
  int          cyc = 0;
  bit          skip_b_sc = 0;
  int          bub_a, bub_b;

  hazard_scoreboard dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_branch(id_branch), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_dst(id_dst),
    .flush(flush), .perf_clr(perf_clr), .pc_write(a_pc_write), .ifid_write(a_ifid_write),
    .bubble(a_bubble), .stall_cause(a_cause), .stall_count(a_sc)
  );

  hazard_scoreboard #(.LOAD_LAT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_branch(id_branch), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_dst(id_dst),
    .flush(flush), .perf_clr(perf_clr), .pc_write(b_pc_write), .ifid_write(b_ifid_write),
    .bubble(b_bubble), .stall_cause(b_cause), .stall_count(b_sc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int rem(int k, int r);
    if (r == 0) return 0;
    return (ready_at[k][r] > cyc) ? ready_at[k][r] - cyc : 0;
  endfunction

  function automatic void mdl(input int k, output bit st, output logic [1:0] cs);
    bit raw = 0;
    bit waw;
    for (int i = 0; i < 2; i++) begin
      int s = int'(id_src[i*5 +: 5]);
      if (id_src_used[i] && s != 0 && rem(k, s) > (id_branch ? 0 : 1)) raw = 1;
    end
    waw = id_regwrite && id_dst != 0 && rem(k, int'(id_dst)) > (id_memread ? lload[k] : 1);
    st  = id_valid && !flush && (raw || waw);
    cs  = !st ? 2'd0 : (raw && id_branch) ? 2'd2 : raw ? 2'd1 : 2'd3;
  endfunction

  function automatic void mdl_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) ready_at[k][r] = 0;
      sc_m[k] = 32'd0;
    end
  endfunction

  task automatic step();
    bit         st [2];
    logic [1:0] cs [2];
    mdl(0, st[0], cs[0]);
    mdl(1, st[1], cs[1]);
    #2;
    chk("a_pc_write", a_pc_write, {31'b0, !st[0]});
    chk("a_ifid_write", a_ifid_write, {31'b0, !st[0]});
    chk("a_bubble", a_bubble, {31'b0, st[0]});
    chk("a_cause", a_cause, {30'b0, cs[0]});
    chk("a_stall_count", a_sc, sc_m[0]);
    chk("b_pc_write", b_pc_write, {31'b0, !st[1]});
    chk("b_bubble", b_bubble, {31'b0, st[1]});
    chk("b_cause", b_cause, {30'b0, cs[1]});
    if (!skip_b_sc) chk("b_stall_count", b_sc, sc_m[1]);
    bub_a += int'(a_bubble);
    bub_b += int'(b_bubble);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!st[k] && id_valid && !flush && id_regwrite && id_dst != 0)
        ready_at[k][id_dst] = cyc + 1 + (id_memread ? lload[k] : 1);
      if (perf_clr)                          sc_m[k] = 32'd0;
      else if (st[k] && sc_m[k] != '1)       sc_m[k] = sc_m[k] + 32'd1;
    end
    cyc++;
    #1;
  endtask

  task automatic set_ins(input bit v, input int s0, input bit u0, input int s1, input bit u1,
                         input bit br, input bit rw, input bit mr, input int dst);
    id_valid    = v;
    id_src      = {5'(s1), 5'(s0)};
    id_src_used = {u1, u0};
    id_branch   = br;
    id_regwrite = rw;
    id_memread  = mr;
    id_dst      = 5'(dst);
    flush       = 1'b0;
    perf_clr    = 1'b0;
  endtask

  task automatic idle();                  set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic lw(input int d);         set_ins(1, 0, 0, 0, 0, 0, 1, 1, d); endtask
  task automatic add(input int d, input int s0, input int s1); set_ins(1, s0, 1, s1, 1, 0, 1, 0, d); endtask
  task automatic addi(input int d, input int s0); set_ins(1, s0, 1, 0, 0, 0, 1, 0, d); endtask
  task automatic beq(input int s0, input int s1); set_ins(1, s0, 1, s1, 1, 1, 0, 0, 0); endtask

  task automatic drain();
    idle();
    repeat (6) step();
  endtask

  // Holds the current instruction until configuration k issues it; counts DUT bubbles meanwhile.
  task automatic hold_until(input int k);
    bit         st;
    logic [1:0] cs;
    int         n = 0;
    bub_a = 0;
    bub_b = 0;
    forever begin
      mdl(k, st, cs);
      step();
      if (!st) break;
      n++;
      if (n > 10) begin
        total++;
        bad++;
        $error("FAIL hold_timeout observed=%0d expected<=10", n);
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    mdl_reset();
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step();

    drain();
    lw(8); step();
    add(10, 8, 9); hold_until(1);
    chk("loaduse_stalls_a", bub_a, 1);
    chk("loaduse_stalls_b", bub_b, 3);
    chk("loaduse_count_a", a_sc, 1);

    drain();
    add(8, 1, 2); step();
    beq(8, 9); hold_until(1);
    chk("alu_branch_stalls_a", bub_a, 1);
    chk("alu_branch_stalls_b", bub_b, 1);

    drain();
    lw(8); step();
    beq(8, 0); hold_until(1);
    chk("load_branch_stalls_a", bub_a, 2);
    chk("load_branch_stalls_b", bub_b, 4);

    drain();
    lw(0); step();
    add(1, 0, 0); hold_until(1);
    chk("reg0_stalls_a", bub_a, 0);
    chk("reg0_stalls_b", bub_b, 0);

    drain();
    lw(5); step();
    addi(5, 6); hold_until(1);
    chk("waw_stalls_a", bub_a, 1);
    chk("waw_stalls_b", bub_b, 3);
    beq(5, 0); hold_until(1);
    chk("waw_reload_a", bub_a, 1);
    chk("waw_reload_b", bub_b, 1);

    drain();
    lw(8); step();
    add(11, 8, 9); flush = 1'b1; step();
    add(10, 8, 9); hold_until(1);
    chk("flush_decay_a", bub_a, 0);
    chk("flush_decay_b", bub_b, 2);
    beq(11, 0); hold_until(1);
    chk("flush_noset_a", bub_a, 0);
    chk("flush_noset_b", bub_b, 0);

    drain();
    lw(8); step();
    add(10, 8, 9); perf_clr = 1'b1; step();
    perf_clr = 1'b0;
    #2;
    chk("perf_clr_a", a_sc, 0);
    chk("perf_clr_b", b_sc, 0);
    hold_until(1);

    drain();
    for (int n = 0; n < 400; n++) begin
      set_ins($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
              $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
              $urandom_range(0, 4) < 3, $urandom_range(0, 4) < 2, $urandom_range(0, 7));
      flush    = $urandom_range(0, 9) == 0;
      perf_clr = $urandom_range(0, 31) == 0;
      step();
    end

    drain();
    lw(8); step();
    add(9, 8, 0);
    #2;
    chk("pre_reset_bubble_a", a_bubble, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_bubble_a", a_bubble, 0);
    chk("reset_pc_write_a", a_pc_write, 1);
    chk("reset_cause_a", a_cause, 0);
    chk("reset_bubble_b", b_bubble, 0);
    chk("reset_ifid_b", b_ifid_write, 1);
    mdl_reset();
    @(posedge clk);
    cyc++;
    #1 rst_n = 1'b1;
    step();
    chk("post_reset_count_a", a_sc, 0);

    drain();
    lw(5); step();
    beq(5, 0);
    skip_b_sc = 1;
    force dut_b.r_stall_count = 32'hFFFF_FFFD;
    step();
    release dut_b.r_stall_count;
    hold_until(1);
    skip_b_sc = 0;
    chk("saturate_b", b_sc, 32'hFFFF_FFFF);
    sc_m[1] = 32'hFFFF_FFFF;
    idle(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
